// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - N-channel RAM port arbiter with capped priority channel, round-robin and watchdog
module ram_port_arbiter #(
    parameter int NCH      = 4,
    parameter int AW       = 22,
    parameter int DW       = 32,
    parameter int PRIO_CH  = 0,
    parameter int MAXBURST = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_write,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    output logic [NCH-1:0]    ch_ready,
    output logic [NCH-1:0]    ch_done,
    output logic [NCH-1:0]    ch_err,
    output logic [DW-1:0]     ch_rdata,
    output logic [NCH-1:0]    ch_grant,
    output logic              mem_req,
    output logic              mem_write,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy
);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_RELEASE} state_t;

    state_t         r_state, w_state_nxt;
    logic [IW-1:0]  r_owner, r_rr_last, w_rr_idx, w_win;
    logic [3:0]     r_prio_run;
    logic [WDW-1:0] r_wd;
    logic           w_rr_found, w_prio_ok, w_any, w_wd_hit;
    logic           w_ready_p, w_done_p, w_err_p;
    logic [NCH-1:0] w_owner_oh, w_win_oh;
    logic [AW-1:0]  w_sel_addr;
    logic [DW-1:0]  w_sel_wdata;
    logic           w_sel_write;

    // Round-robin scan starts just after the last non-priority winner.
    always_comb begin : rr_scan
        int            idx;
        logic [IW-1:0] cand;
        idx        = 0;
        cand       = '0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = int'(r_rr_last) + k;
            if (idx >= NCH) idx = idx - NCH;
            cand = IW'(idx);
            if (!w_rr_found && idx != PRIO_CH && ch_req[cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = cand;
            end
        end
    end

    assign w_any      = |ch_req;
    assign w_prio_ok  = ch_req[PRIO_CH] && ((r_prio_run < 4'(MAXBURST)) || !w_rr_found);
    assign w_win      = w_prio_ok ? IW'(PRIO_CH) : w_rr_idx;
    assign w_win_oh   = NCH'(1) << w_win;
    assign w_owner_oh = NCH'(1) << r_owner;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_win == IW'(i)) begin
                w_sel_addr  = ch_addr[i*AW +: AW];
                w_sel_wdata = ch_wdata[i*DW +: DW];
                w_sel_write = ch_write[i];
            end
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wd
            assign w_wd_hit = (r_wd == WDW'(TIMEOUT - 1));
        end else begin : g_no_wd
            assign w_wd_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE:     if (mem_ready) w_state_nxt = mem_done ? S_RELEASE : S_WAIT_DONE;
                         else if (w_wd_hit) w_state_nxt = S_RELEASE;
            S_WAIT_DONE: if (mem_done || w_wd_hit) w_state_nxt = S_RELEASE;
            S_RELEASE:   if (!ch_req[r_owner]) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Completion takes precedence over a watchdog expiry on the same edge.
    always_comb begin
        w_ready_p = 1'b0;
        w_done_p  = 1'b0;
        w_err_p   = 1'b0;
        case (r_state)
            S_ISSUE: begin
                if (mem_ready) begin
                    w_ready_p = 1'b1;
                    w_done_p  = mem_done;
                end else if (w_wd_hit) begin
                    w_err_p = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (mem_done)      w_done_p = 1'b1;
                else if (w_wd_hit) w_err_p  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_ready   <= '0;
            ch_done    <= '0;
            ch_err     <= '0;
            ch_rdata   <= '0;
            ch_grant   <= '0;
            mem_req    <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            r_owner    <= '0;
            r_rr_last  <= IW'(NCH - 1);
            r_prio_run <= '0;
            r_wd       <= '0;
        end else begin
            ch_ready <= w_ready_p ? w_owner_oh : '0;
            ch_done  <= w_done_p  ? w_owner_oh : '0;
            ch_err   <= w_err_p   ? w_owner_oh : '0;
            busy     <= (w_state_nxt != S_IDLE);
            if (w_done_p) ch_rdata <= mem_rdata;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner   <= w_win;
                        ch_grant  <= w_win_oh;
                        mem_req   <= 1'b1;
                        mem_addr  <= w_sel_addr;
                        mem_wdata <= w_sel_wdata;
                        mem_write <= w_sel_write;
                        r_wd      <= '0;
                        if (w_prio_ok) begin
                            if (r_prio_run != 4'(MAXBURST)) r_prio_run <= r_prio_run + 4'd1;
                        end else begin
                            r_prio_run <= '0;
                            r_rr_last  <= w_win;
                        end
                    end
                end
                S_ISSUE, S_WAIT_DONE: begin
                    r_wd <= r_wd + 1'b1;
                    if (w_ready_p || w_err_p) mem_req <= 1'b0;
                end
                S_RELEASE: begin
                    if (!ch_req[r_owner]) ch_grant <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter against a transaction-level model
module tb_ram_port_arbiter;
    localparam int NCH = 4, AW = 22, DW = 32, P = 0, MB = 4, TO = 15;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [NCH-1:0]    ch_req = '0, ch_write = '0;
    logic [NCH*AW-1:0] ch_addr = '0;
    logic [NCH*DW-1:0] ch_wdata = '0;
    logic [NCH-1:0]    ch_ready, ch_done, ch_err, ch_grant;
    logic [DW-1:0]     ch_rdata, mem_wdata;
    logic              mem_req, mem_write, busy;
    logic [AW-1:0]     mem_addr;
    logic              mem_ready = 1'b0, mem_done = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO_CH(P), .MAXBURST(MB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_write(ch_write), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_ready(ch_ready), .ch_done(ch_done), .ch_err(ch_err),
        .ch_rdata(ch_rdata), .ch_grant(ch_grant), .mem_req(mem_req), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_vec = 0, n_err = 0, cyc = 0;
    int remaining[NCH];
    logic [AW-1:0] a_addr[NCH];
    logic [DW-1:0] a_wdata[NCH];
    logic          a_write[NCH];
    int   cp, cw, c_rdy_wait, c_done_wait;
    bit   c_hang, c_coincide;
    logic [DW-1:0] c_data;

    int   m_owner, m_age, m_prun, m_rrl;
    bit   m_acc, m_fin;
    logic [NCH-1:0] e_grant, e_ready, e_done, e_err;
    logic [DW-1:0]  e_rdata, e_mwdata;
    logic [AW-1:0]  e_maddr;
    logic           e_mreq, e_mwrite;

    int glog[$], dlog[$], expq[$];
    int t_grant0, t_glast, t_ready, t_done, t_err, n_done;
    logic err_mreq;
    logic [AW-1:0]  cap_addr;
    logic [NCH-1:0] prev_grant;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_seq(string nm, int q[$], int e[$]);
        chk({nm, "_len"}, q.size(), e.size());
        for (int i = 0; i < q.size() && i < e.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), q[i], e[i]);
    endtask

    function automatic int oh2i(logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Priority channel wins until its run reaches the cap, unless nobody else is waiting.
    function automatic int pick();
        bit others = 1'b0;
        for (int i = 0; i < NCH; i++) if (i != P && ch_req[i]) others = 1'b1;
        if (ch_req[P] && (m_prun < MB || !others)) return P;
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m_rrl + k) % NCH;
            if (c != P && ch_req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_prun = 0; m_rrl = NCH - 1; m_acc = 0; m_fin = 0;
        e_grant = '0; e_ready = '0; e_done = '0; e_err = '0; e_rdata = '0;
        e_mwdata = '0; e_maddr = '0; e_mreq = 1'b0; e_mwrite = 1'b0;
    endtask

    task automatic model_step();
        int g;
        e_ready = '0; e_done = '0; e_err = '0;
        if (m_owner < 0) begin
            if (ch_req != '0) begin
                g = pick();
                m_owner = g;
                if (g == P) m_prun = (m_prun < MB) ? m_prun + 1 : MB;
                else begin m_prun = 0; m_rrl = g; end
                e_grant = NCH'(1) << g;
                e_mreq = 1'b1;
                e_maddr = ch_addr[g*AW +: AW];
                e_mwdata = ch_wdata[g*DW +: DW];
                e_mwrite = ch_write[g];
                m_acc = 0; m_fin = 0; m_age = 0;
                glog.push_back(g);
            end
        end else if (!m_fin) begin
            m_age++;
            if (!m_acc && mem_ready) begin
                m_acc = 1; e_mreq = 1'b0; e_ready = NCH'(1) << m_owner;
                if (mem_done) begin e_done = NCH'(1) << m_owner; e_rdata = mem_rdata; m_fin = 1; end
            end else if (m_acc && mem_done) begin
                e_done = NCH'(1) << m_owner; e_rdata = mem_rdata; m_fin = 1;
            end else if (m_age == TO) begin
                e_err = NCH'(1) << m_owner; e_mreq = 1'b0; m_fin = 1;
            end
        end else if (!ch_req[m_owner]) begin
            m_owner = -1; e_grant = '0;
        end
    endtask

    task automatic compare();
        chk("grant", ch_grant, e_grant);
        chk("ready", ch_ready, e_ready);
        chk("done", ch_done, e_done);
        chk("err", ch_err, e_err);
        chk("rdata", ch_rdata, e_rdata);
        chk("mem_req", mem_req, e_mreq);
        chk("mem_addr", mem_addr, e_maddr);
        chk("mem_wdata", mem_wdata, e_mwdata);
        chk("mem_write", mem_write, e_mwrite);
        chk("busy", busy, m_owner >= 0);
    endtask

    task automatic observe();
        if (ch_grant != '0 && prev_grant == '0) begin
            dlog.push_back(oh2i(ch_grant));
            if (t_grant0 < 0) begin t_grant0 = cyc; cap_addr = mem_addr; end
            t_glast = cyc;
        end
        if (ch_ready != '0) t_ready = cyc;
        if (ch_done != '0) begin t_done = cyc; n_done++; end
        if (ch_err != '0) begin t_err = cyc; err_mreq = mem_req; end
        prev_grant = ch_grant;
    endtask

    // Requesters drop for one cycle after each completion; controller answers with fixed latencies.
    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            if (ch_done[i] || ch_err[i]) begin
                if (remaining[i] > 0) remaining[i]--;
                ch_req[i] = 1'b0;
            end else begin
                ch_req[i] = (remaining[i] > 0);
            end
            ch_addr[i*AW +: AW]  = a_addr[i];
            ch_wdata[i*DW +: DW] = a_wdata[i];
            ch_write[i]          = a_write[i];
        end
        mem_ready = 1'b0;
        mem_done  = 1'b0;
        if (!c_hang) begin
            if (cp == 0) begin
                if (mem_req) begin
                    cw++;
                    if (cw >= c_rdy_wait) begin
                        mem_ready = 1'b1; cw = 0;
                        if (c_coincide) begin
                            mem_done = 1'b1; mem_rdata = c_data; c_data = c_data + 32'h0101_0101;
                        end else cp = 1;
                    end
                end
            end else begin
                cw++;
                if (cw >= c_done_wait) begin
                    mem_done = 1'b1; mem_rdata = c_data; c_data = c_data + 32'h0101_0101;
                    cp = 0; cw = 0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare();
        observe();
        drive();
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NCH; i++) if (remaining[i] != 0) return 1'b0;
        return (m_owner < 0) && (ch_req == '0);
    endfunction

    task automatic run(int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin tick(); n++; end
        chk("run_budget", n < budget, 1);
    endtask

    task automatic clear_logs();
        glog.delete(); dlog.delete();
        t_grant0 = -1; t_glast = -1; t_ready = -1; t_done = -1; t_err = -1; n_done = 0;
        err_mreq = 1'bx; cap_addr = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ch_req = '0; mem_ready = 1'b0; mem_done = 1'b0;
        for (int i = 0; i < NCH; i++) remaining[i] = 0;
        cp = 0; cw = 0; c_hang = 0; c_coincide = 0; c_rdy_wait = 1; c_done_wait = 1;
        prev_grant = '0;
        model_reset();
        #1 compare();
        @(negedge clk);
        compare();
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NCH; i++) begin
            a_addr[i]  = AW'(32'h1000 * (i + 1) + 32'h10 * i);
            a_wdata[i] = 32'hA500_0000 | 32'(i);
            a_write[i] = 1'b0;
        end
        clear_logs();
        do_reset();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_grant", ch_grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", ch_rdata, 0);

        // single read with minimum latency
        clear_logs(); a_addr[1] = 22'h000123; remaining[1] = 1; c_data = 32'hDEADBEEF;
        drive(); run(40);
        expq = {1}; chk_seq("t1_order", dlog, expq);
        chk("t1_addr", cap_addr, 22'h000123);
        chk("t1_rdy_lat", t_ready - t_grant0, 1);
        chk("t1_done_lat", t_done - t_grant0, 2);
        chk("t1_rdata", ch_rdata, 32'hDEADBEEF);

        // round-robin among non-priority channels
        do_reset(); clear_logs();
        remaining[1] = 2; remaining[2] = 2; remaining[3] = 2; a_write[2] = 1'b1; c_data = 32'h1111_0000;
        drive(); run(200);
        expq = {1, 2, 3, 1, 2, 3};
        chk_seq("t2_dut", dlog, expq);
        chk_seq("t2_model", glog, expq);

        // priority burst cap
        do_reset(); clear_logs(); a_write[2] = 1'b0;
        remaining[0] = 8; remaining[2] = 2; c_data = 32'h2222_0000;
        drive(); run(300);
        expq = {0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
        chk_seq("t3_dut", dlog, expq);
        chk_seq("t3_model", glog, expq);

        // priority channel alone never stalls
        do_reset(); clear_logs(); remaining[0] = 10; c_data = 32'h3333_0000;
        drive(); run(200);
        expq = {0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        chk_seq("t4_dut", dlog, expq);
        chk("t4_span", t_glast - t_grant0, 36);

        // watchdog abort and stray completion
        do_reset(); clear_logs(); remaining[3] = 1; c_data = 32'hCAFEF00D;
        drive(); run(40);
        chk("t5_pre_rdata", ch_rdata, 32'hCAFEF00D);
        clear_logs(); c_hang = 1; remaining[3] = 1;
        drive(); run(60);
        chk("t5_err_lat", t_err - t_grant0, 15);
        chk("t5_err_mreq", err_mreq, 0);
        chk("t5_no_done", n_done, 0);
        mem_done = 1'b1; mem_rdata = 32'h1;
        tick(); tick();
        chk("t5_stray", ch_rdata, 32'hCAFEF00D);

        // ready and done on the same cycle
        do_reset(); clear_logs(); c_coincide = 1; c_data = 32'h5A5A5A5A; remaining[2] = 1;
        drive(); run(40);
        chk("t6_same", t_done - t_ready, 0);
        chk("t6_rdy_lat", t_ready - t_grant0, 1);
        chk("t6_rdata", ch_rdata, 32'h5A5A5A5A);

        // reset while waiting for completion
        do_reset(); clear_logs(); c_done_wait = 5; c_data = 32'h0000_0055; remaining[1] = 1;
        drive(); tick(); tick(); tick();
        chk("t7_busy_mid", busy, 1);
        do_reset();
        chk("t7_mem_req", mem_req, 0);
        chk("t7_grant", ch_grant, 0);
        chk("t7_busy", busy, 0);
        clear_logs(); c_data = 32'h0000_0077; remaining[1] = 1;
        drive(); run(40);
        expq = {1}; chk_seq("t7_order", dlog, expq);
        chk("t7_rdata", ch_rdata, 32'h0000_0077);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Parametrised N-channel arbiter that shares one RAM-controller port among several requesters (CPU SDRAM path, CPU VRAM path, VGA refill, microcode RAM). It replaces the fixed per-client req/ready/done wiring between the top level and the RAM controller. It adds a latency-critical priority channel with a burst cap, round-robin among the remaining channels, and a per-transaction watchdog that aborts hung transfers.

## Interface
Parameters:
- NCH, 4: number of requester channels (2..8).
- AW, 22: address width.
- DW, 32: data width.
- PRIO_CH, 0: index of the priority channel (VGA).
- MAXBURST, 4: maximum consecutive PRIO_CH grants while another channel waits (1..15).
- TIMEOUT, 1023: watchdog limit in cycles from issue; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ch_req  in  NCH  per-channel request; held with addr/write/wdata stable until ch_done or ch_err.
- ch_write  in  NCH  per-channel write strobe (1 = write).
- ch_addr  in  NCH*AW  flattened addresses; channel i is at [i*AW +: AW].
- ch_wdata  in  NCH*DW  flattened write data.
- ch_ready  out  NCH  one-cycle pulse: the controller has accepted the channel's request.
- ch_done  out  NCH  one-cycle pulse: transaction complete; ch_rdata valid this cycle.
- ch_err  out  NCH  one-cycle pulse: watchdog abort.
- ch_rdata  out  DW  shared read-data register.
- ch_grant  out  NCH  one-hot current owner; 0 when idle.
- mem_req  out  1  request to the RAM controller.
- mem_write  out  1  write qualifier.
- mem_addr  out  AW  registered address.
- mem_wdata  out  DW  registered write data.
- mem_ready  in  1  controller accepted mem_req.
- mem_done  in  1  controller completed; mem_rdata valid.
- mem_rdata  in  DW  read data.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, RELEASE. Reset state: IDLE.
- IDLE:
  - If any ch_req bit is set, pick winner g.
  - Latch ch_addr/ch_wdata/ch_write of g into mem_addr/mem_wdata/mem_write.
  - Set ch_grant to one-hot g, assert mem_req, clear the watchdog, go to ISSUE.
- Arbitration:
  - PRIO_CH wins if requesting and prio_run < MAXBURST.
  - Otherwise round-robin over the other requesting channels, starting at rr_last+1 and wrapping at NCH-1 -> 0 (PRIO_CH skipped).
  - If PRIO_CH is the only requester it wins regardless of prio_run.
  - prio_run increments on each PRIO_CH grant and saturates at MAXBURST. It clears on any non-PRIO grant.
  - rr_last updates only on non-PRIO grants.
- ISSUE:
  - mem_req is held high.
  - On mem_ready: deassert mem_req, pulse ch_ready[g], go to WAIT_DONE.
  - If mem_done is high in the same cycle as mem_ready: also capture mem_rdata, pulse ch_done[g] together with ch_ready[g], and go to RELEASE.
- WAIT_DONE: on mem_done, capture mem_rdata into ch_rdata, pulse ch_done[g], go to RELEASE.
- RELEASE: wait until ch_req[g]==0, then clear ch_grant and go to IDLE.
  - Prevents a held request from being double-serviced.
- Watchdog (TIMEOUT != 0):
  - Counter runs in ISSUE and WAIT_DONE.
  - When it reaches TIMEOUT: drop mem_req, pulse ch_err[g] (no ch_done), go to RELEASE.
  - A stray mem_done arriving after the abort, in RELEASE or IDLE, is ignored; ch_rdata is not updated.
- Requests are not cancellable. If ch_req[g] drops during ISSUE or WAIT_DONE, the transaction still completes and is reported. RELEASE then exits immediately.
- ch_rdata holds its last value between reads. Writes do not change it.

## Timing
- Reset values:
  - mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - ch_ready=0, ch_done=0, ch_err=0, ch_rdata=0, ch_grant=0, busy=0.
  - prio_run=0, rr_last=NCH-1, watchdog=0.
- All outputs are registered.
- Minimum read latency: ch_req sampled at edge 0 -> mem_req high after edge 0.
  - mem_ready at edge 1 -> ch_ready pulse after edge 1.
  - mem_done at edge 2 -> ch_done and ch_rdata after edge 2.
- Back-to-back service needs at least one RELEASE cycle and one IDLE cycle between grants.
- Watchdog: ch_err asserts exactly TIMEOUT cycles after the first mem_req cycle.
- Asserting reset_n low mid-transaction clears everything immediately. No pulses are emitted and the controller sees mem_req fall asynchronously.

## Test plan
- Single read, ch1, addr 0x000123: controller returns ready+1 and done+2 with data 0xDEADBEEF -> mem_addr=0x000123, ch_ready[1] then ch_done[1] as 1-cycle pulses, ch_rdata=0xDEADBEEF.
- ch1, ch2 and ch3 request continuously, MAXBURST=4 -> grant order 1,2,3,1,2,3; each ch_done is followed by RELEASE/IDLE before the next grant.
- ch0 (PRIO) and ch2 request continuously -> grants 0,0,0,0,2,0,0,0,0,2.
- ch0 alone requests for 10 transactions -> all 10 granted with no stall.
- Controller never asserts mem_done, TIMEOUT=15 -> ch_err pulses 15 cycles after the first mem_req cycle, mem_req=0, no ch_done. A later mem_done with 0x1 leaves ch_rdata unchanged.
- mem_ready and mem_done coincide, data 0x5A5A5A5A -> ch_ready and ch_done pulse on the same cycle with ch_rdata=0x5A5A5A5A.
- reset_n pulsed low while in WAIT_DONE -> all outputs return to their reset values; the next request is served normally.
